// File: rtl/operand_forward_ctrl.sv
// Hazard and forwarding controller for the 5-stage core: tracks EX/MEM/WB
// destinations, registers ALU operand-mux selects and raises the load-use stall.
module operand_forward_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter bit ENABLE_FWD = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [ADDR_WIDTH-1:0] id_rs1,
  input  logic [ADDR_WIDTH-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [ADDR_WIDTH-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  hold,
  input  logic                  flush,
  output logic [1:0]            fwd_sel_a,
  output logic [1:0]            fwd_sel_b,
  output logic                  stall
);

  typedef logic [ADDR_WIDTH-1:0] reg_idx_t;

  localparam logic [1:0] SEL_RF   = 2'd0;
  localparam logic [1:0] SEL_EX   = 2'd1;
  localparam logic [1:0] SEL_MEM  = 2'd2;
  localparam logic [1:0] SEL_HOLD = 2'd3;

  // _p0 = EX, _p1 = MEM, _p2 = WB
  logic     vld_p0, vld_p1, vld_p2;
  reg_idx_t rd_p0, rd_p1, rd_p2;
  logic     wr_p0, wr_p1, wr_p2;
  logic     ld_p0;

  logic       hit_ex_a, hit_mem_a, hit_wb_a;
  logic       hit_ex_b, hit_mem_b, hit_wb_b;
  logic [1:0] sel_a_nxt, sel_b_nxt;
  logic       hazard;

  // x0 is hard-wired zero, so it never counts as produced
  function automatic logic produces(input logic vld, input logic wr,
                                    input reg_idx_t rd, input reg_idx_t r);
    return vld & wr & (rd == r) & (r != '0);
  endfunction

  function automatic logic [1:0] pick(input logic hit_ex, input logic hit_mem,
                                      input logic hit_wb);
    if (hit_ex)       return SEL_EX;
    else if (hit_mem) return SEL_MEM;
    else if (hit_wb)  return SEL_HOLD;
    else              return SEL_RF;
  endfunction

  always_comb begin
    hit_ex_a  = id_use_rs1 & produces(vld_p0, wr_p0, rd_p0, id_rs1);
    hit_mem_a = id_use_rs1 & produces(vld_p1, wr_p1, rd_p1, id_rs1);
    hit_wb_a  = id_use_rs1 & produces(vld_p2, wr_p2, rd_p2, id_rs1);
    hit_ex_b  = id_use_rs2 & produces(vld_p0, wr_p0, rd_p0, id_rs2);
    hit_mem_b = id_use_rs2 & produces(vld_p1, wr_p1, rd_p1, id_rs2);
    hit_wb_b  = id_use_rs2 & produces(vld_p2, wr_p2, rd_p2, id_rs2);

    sel_a_nxt = SEL_RF;
    sel_b_nxt = SEL_RF;
    hazard    = 1'b0;
    if (ENABLE_FWD) begin
      sel_a_nxt = pick(hit_ex_a, hit_mem_a, hit_wb_a);
      sel_b_nxt = pick(hit_ex_b, hit_mem_b, hit_wb_b);
      hazard    = ld_p0 & (hit_ex_a | hit_ex_b);
    end else begin
      hazard = hit_ex_a | hit_mem_a | hit_wb_a | hit_ex_b | hit_mem_b | hit_wb_b;
    end

    stall = id_valid & ~hold & ~rst & hazard;
  end

  // ---- ID -> EX (p0), EX -> MEM (p1), MEM -> WB (p2) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      rd_p0     <= '0;
      rd_p1     <= '0;
      rd_p2     <= '0;
      wr_p0     <= 1'b0;
      wr_p1     <= 1'b0;
      wr_p2     <= 1'b0;
      ld_p0     <= 1'b0;
      fwd_sel_a <= SEL_RF;
      fwd_sel_b <= SEL_RF;
    end else if (!hold) begin
      vld_p1 <= vld_p0;
      rd_p1  <= rd_p0;
      wr_p1  <= wr_p0;
      vld_p2 <= vld_p1;
      rd_p2  <= rd_p1;
      wr_p2  <= wr_p1;
      // flush outranks stall; either way EX takes a bubble
      if (flush || stall) begin
        vld_p0    <= 1'b0;
        rd_p0     <= '0;
        wr_p0     <= 1'b0;
        ld_p0     <= 1'b0;
        fwd_sel_a <= SEL_RF;
        fwd_sel_b <= SEL_RF;
      end else begin
        vld_p0    <= id_valid;
        rd_p0     <= id_rd;
        wr_p0     <= id_reg_write;
        ld_p0     <= id_mem_read;
        fwd_sel_a <= sel_a_nxt;
        fwd_sel_b <= sel_b_nxt;
      end
    end
  end

endmodule

// File: tb/tb_operand_forward_ctrl.sv
// Bench for operand_forward_ctrl: two instances (forwarding on / off) share the
// ID inputs and are checked every cycle against an in-flight-instruction model.
module tb_operand_forward_ctrl;

  logic       clk = 1'b0;
  logic       rst, id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
  logic       hold, flush;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [1:0] sel_a_f, sel_b_f, sel_a_n, sel_b_n;
  logic       stall_f, stall_n;

  always #5 clk = ~clk;

  operand_forward_ctrl #(.ADDR_WIDTH(5), .ENABLE_FWD(1'b1)) u_fwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .hold(hold),
    .flush(flush), .fwd_sel_a(sel_a_f), .fwd_sel_b(sel_b_f), .stall(stall_f));

  operand_forward_ctrl #(.ADDR_WIDTH(5), .ENABLE_FWD(1'b0)) u_nofwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .hold(hold),
    .flush(flush), .fwd_sel_a(sel_a_n), .fwd_sel_b(sel_b_n), .stall(stall_n));

  int total = 0;
  int bad   = 0;

  // Model: per instance e (0 = forwarding, 1 = no forwarding), slot s holds the
  // instruction s cycles past ID (0 = EX, 1 = MEM, 2 = WB).
  bit         m_vld[2][3];
  logic [4:0] m_rd[2][3];
  bit         m_wr[2][3];
  bit         m_ld[2];
  logic [1:0] m_sa[2], m_sb[2];
  bit         m_known = 1'b0;
  logic       last_sf, last_sn;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit prod(int e, int s, logic [4:0] r);
    return m_vld[e][s] && m_wr[e][s] && (m_rd[e][s] == r) && (r != 5'd0);
  endfunction

  // Nearest (youngest) producer wins; distance 1/2/3 maps straight to the code.
  function automatic logic [1:0] code(int e, bit use_r, logic [4:0] r);
    if (!use_r || e == 1) return 2'd0;
    for (int s = 0; s < 3; s++)
      if (prod(e, s, r)) return 2'(s + 1);
    return 2'd0;
  endfunction

  function automatic bit hazard(int e, bit u1, logic [4:0] r1, bit u2, logic [4:0] r2);
    bit h = 1'b0;
    if (e == 0)
      return m_ld[0] && ((u1 && prod(0, 0, r1)) || (u2 && prod(0, 0, r2)));
    for (int s = 0; s < 3; s++)
      h |= (u1 && prod(e, s, r1)) || (u2 && prod(e, s, r2));
    return h;
  endfunction

  task automatic cyc(input bit v, input logic [4:0] rd, input bit wr, input bit ld,
                     input logic [4:0] r1, input bit u1, input logic [4:0] r2, input bit u2,
                     input bit hd, input bit fl, input bit rs);
    bit         es[2];
    logic [1:0] ca[2], cb[2];
    id_valid = v; id_rd = rd; id_reg_write = wr; id_mem_read = ld;
    id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
    hold = hd; flush = fl; rst = rs;
    #1;
    last_sf = stall_f;
    last_sn = stall_n;
    for (int e = 0; e < 2; e++) begin
      es[e] = !rs && !hd && v && hazard(e, u1, r1, u2, r2);
      ca[e] = code(e, u1, r1);
      cb[e] = code(e, u2, r2);
      chk(e ? "nofwd_stall" : "fwd_stall", e ? stall_n : stall_f, 2'(es[e]));
      if (m_known) begin
        chk(e ? "nofwd_sel_a" : "fwd_sel_a", e ? sel_a_n : sel_a_f, m_sa[e]);
        chk(e ? "nofwd_sel_b" : "fwd_sel_b", e ? sel_b_n : sel_b_f, m_sb[e]);
      end
    end
    @(posedge clk);
    #2;
    for (int e = 0; e < 2; e++) begin
      if (rs) begin
        for (int s = 0; s < 3; s++) begin
          m_vld[e][s] = 0; m_rd[e][s] = 0; m_wr[e][s] = 0;
        end
        m_ld[e] = 0; m_sa[e] = 0; m_sb[e] = 0;
      end else if (!hd) begin
        for (int s = 2; s > 0; s--) begin
          m_vld[e][s] = m_vld[e][s-1]; m_rd[e][s] = m_rd[e][s-1]; m_wr[e][s] = m_wr[e][s-1];
        end
        if (fl || es[e]) begin
          m_vld[e][0] = 0; m_wr[e][0] = 0; m_ld[e] = 0; m_sa[e] = 0; m_sb[e] = 0;
        end else begin
          m_vld[e][0] = v; m_rd[e][0] = rd; m_wr[e][0] = wr; m_ld[e] = ld;
          m_sa[e] = ca[e]; m_sb[e] = cb[e];
        end
      end
    end
    if (rs) m_known = 1'b1;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                     input bit hd = 0, input bit fl = 0, input bit rs = 0);
    cyc(1, rd, 1, 0, r1, 1, r2, 1, hd, fl, rs);
  endtask

  task automatic load(input logic [4:0] rd, input logic [4:0] r1,
                      input bit hd = 0, input bit fl = 0, input bit rs = 0);
    cyc(1, rd, 1, 1, r1, 1, 5'd0, 0, hd, fl, rs);
  endtask

  task automatic nop(input bit hd = 0, input bit fl = 0, input bit rs = 0);
    cyc(0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, hd, fl, rs);
  endtask

  initial begin
    nop(0, 0, 1);
    nop(0, 0, 1);
    chk("reset_sel_a", sel_a_f, 2'd0);
    chk("reset_sel_b", sel_b_f, 2'd0);

    // back-to-back ALU dependency
    alu(5, 1, 2);
    alu(6, 5, 7);
    chk("b2b_stall", 2'(last_sf), 2'd0);
    chk("b2b_sel_a", sel_a_f, 2'd1);
    chk("b2b_sel_b", sel_b_f, 2'd0);

    // distance 2, 3, 4
    alu(9, 1, 2); nop(); alu(10, 9, 1);
    chk("dist2_sel_a", sel_a_f, 2'd2);
    alu(9, 1, 2); nop(); nop(); alu(11, 9, 1);
    chk("dist3_sel_a", sel_a_f, 2'd3);
    alu(9, 1, 2); nop(); nop(); nop(); alu(11, 9, 1);
    chk("dist4_sel_a", sel_a_f, 2'd0);

    // load-use: one stall cycle, bubble, then MEM forwarding
    load(4, 1);
    alu(8, 4, 4);
    chk("lu_stall", 2'(last_sf), 2'd1);
    chk("lu_bubble_a", sel_a_f, 2'd0);
    chk("lu_bubble_b", sel_b_f, 2'd0);
    alu(8, 4, 4);
    chk("lu_release_stall", 2'(last_sf), 2'd0);
    chk("lu_sel_a", sel_a_f, 2'd2);
    chk("lu_sel_b", sel_b_f, 2'd2);

    // x0 and youngest-first priority
    alu(0, 1, 2); alu(12, 0, 0);
    chk("x0_sel_a", sel_a_f, 2'd0);
    chk("x0_sel_b", sel_b_f, 2'd0);
    alu(3, 1, 2); alu(3, 1, 2); alu(13, 3, 1);
    chk("prio_sel_a", sel_a_f, 2'd1);

    // hold freezes everything for 3 cycles
    alu(14, 1, 2); alu(15, 14, 1);
    for (int i = 0; i < 3; i++) begin
      alu(16, 15, 14, 1);
      chk("hold_stall", 2'(last_sf), 2'd0);
      chk("hold_sel_a", sel_a_f, 2'd1);
      chk("hold_sel_b", sel_b_f, 2'd0);
    end
    alu(16, 15, 14);
    chk("hold_rel_a", sel_a_f, 2'd1);
    chk("hold_rel_b", sel_b_f, 2'd2);

    // flush together with load-use stall
    load(4, 1);
    alu(8, 4, 4, 0, 1);
    chk("flush_stall_seen", 2'(last_sf), 2'd1);
    chk("flush_bubble_a", sel_a_f, 2'd0);
    alu(17, 8, 4);
    chk("flush_next_stall", 2'(last_sf), 2'd0);
    chk("flush_killed_a", sel_a_f, 2'd0);
    chk("flush_load_b", sel_b_f, 2'd2);

    // reset held through a load-use hazard
    load(4, 1);
    alu(8, 4, 4, 0, 0, 1);
    chk("rst_stall1", 2'(last_sf), 2'd0);
    alu(8, 4, 4, 0, 0, 1);
    chk("rst_stall2", 2'(last_sf), 2'd0);
    chk("rst_sel_a", sel_a_f, 2'd0);
    alu(18, 4, 8);
    chk("rst_after_a", sel_a_f, 2'd0);
    chk("rst_after_b", sel_b_f, 2'd0);

    // no-forwarding instance: stall until the producer leaves WB
    nop(); nop(); nop();
    alu(5, 1, 2);
    for (int i = 0; i < 4; i++) begin
      alu(6, 5, 7);
      chk("nofwd_seq_stall", 2'(last_sn), (i < 3) ? 2'd1 : 2'd0);
    end
    chk("nofwd_seq_sel", sel_a_n, 2'd0);

    // randomized traffic on a small register set to provoke hazards
    for (int i = 0; i < 400; i++) begin
      bit v = ($urandom_range(0, 9) != 0);
      cyc(v, 5'($urandom_range(0, 7)), v & 1'($urandom), v & ($urandom_range(0, 3) == 0),
          5'($urandom_range(0, 7)), v & 1'($urandom), 5'($urandom_range(0, 7)), v & 1'($urandom),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
